// File: rtl/mag_cook_controller.sv
// Magnetron cook controller: button-driven cook FSM with a seconds countdown,
// power-level duty cycling, quick-start/extend, pause/resume and end beep.
module mag_cook_controller #(
  parameter int TIME_W     = 12,
  parameter int PWR_W      = 3,
  parameter int ADD_SECS   = 30,
  parameter int BEEP_TICKS = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power,
  output logic              mag_on,
  output logic              beep,
  output logic              done,
  output logic [TIME_W-1:0] time_left,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COOK   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int                BEEP_W    = (BEEP_TICKS < 2) ? 1 : $clog2(BEEP_TICKS);
  localparam logic [TIME_W:0]   TIME_MAX  = {1'b0, {TIME_W{1'b1}}};
  localparam logic [TIME_W:0]   ADD_EXT   = (TIME_W+1)'(ADD_SECS);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TICKS - 1);

  state_t              state_reg, state_next;
  logic [TIME_W-1:0]   time_left_reg, time_left_next;
  logic [PWR_W-1:0]    phase_reg, phase_next;
  logic [BEEP_W-1:0]   beep_cnt_reg, beep_cnt_next;
  logic                beep_reg, beep_next;
  logic                done_reg, done_next;
  logic [2:0]          btn_hist_reg;
  logic                live_reg;
  logic [2:0]          btn_n;
  logic [2:0]          press;
  logic                start_p, stop_p, clear_p;
  logic [TIME_W:0]     ext_sum;
  logic [TIME_W-1:0]   time_ext;

  assign btn_n = {clearn, stopn, startn};

  // live_reg masks the first edge after reset so a button held through reset
  // release only resamples its level and never counts as a press.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_press
      assign press[gi] = live_reg & btn_hist_reg[gi] & ~btn_n[gi];
    end
  endgenerate

  assign start_p = press[0];
  assign stop_p  = press[1];
  assign clear_p = press[2];

  assign ext_sum  = {1'b0, time_left_reg} + ADD_EXT;
  assign time_ext = (ext_sum > TIME_MAX) ? TIME_MAX[TIME_W-1:0] : ext_sum[TIME_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      time_left_reg <= '0;
      phase_reg     <= '0;
      beep_cnt_reg  <= '0;
      beep_reg      <= 1'b0;
      done_reg      <= 1'b0;
      btn_hist_reg  <= 3'b111;
      live_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      time_left_reg <= time_left_next;
      phase_reg     <= phase_next;
      beep_cnt_reg  <= beep_cnt_next;
      beep_reg      <= beep_next;
      done_reg      <= done_next;
      btn_hist_reg  <= btn_n;
      live_reg      <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    time_left_next = time_left_reg;
    phase_next     = phase_reg;
    beep_cnt_next  = beep_cnt_reg;
    beep_next      = beep_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        phase_next = '0;
        if (clear_p) begin
          time_left_next = '0;
        end else if (start_p && door_closed) begin
          state_next = COOK;
          if (time_left_reg == '0) time_left_next = time_ext;
        end else if (load) begin
          time_left_next = time_in;
        end
      end
      COOK: begin
        if (clear_p) begin
          state_next     = IDLE;
          time_left_next = '0;
          phase_next     = '0;
        end else if (stop_p || !door_closed) begin
          state_next = PAUSED;
        end else if (start_p) begin
          time_left_next = time_ext;
        end else if (tick) begin
          phase_next = phase_reg + 1'b1;
          if (time_left_reg <= TIME_W'(1)) begin
            state_next     = DONE;
            time_left_next = '0;
            done_next      = 1'b1;
            beep_next      = 1'b1;
            beep_cnt_next  = '0;
          end else begin
            time_left_next = time_left_reg - 1'b1;
          end
        end
      end
      PAUSED: begin
        if (clear_p || stop_p) begin
          state_next     = IDLE;
          time_left_next = '0;
          phase_next     = '0;
        end else if (start_p && door_closed) begin
          state_next = COOK;
        end
      end
      DONE: begin
        if ((|press) || !door_closed) begin
          state_next = IDLE;
          beep_next  = 1'b0;
          phase_next = '0;
        end else if (tick) begin
          if (beep_cnt_reg == BEEP_LAST) begin
            state_next = IDLE;
            beep_next  = 1'b0;
            phase_next = '0;
          end else begin
            beep_cnt_next = beep_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Door gating is combinational so the magnetron drops the moment the door opens.
  assign mag_on    = (state_reg == COOK) && door_closed && (phase_reg <= power);
  assign beep      = beep_reg;
  assign done      = done_reg;
  assign time_left = time_left_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_mag_cook_controller.sv
// Directed bench for mag_cook_controller: expected values are queued as
// stimulus is applied and popped when the matching output is observed.
module tb_mag_cook_controller;

  localparam int TIME_W = 12;
  localparam int PWR_W  = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              tick;
  logic              startn, stopn, clearn;
  logic              door_closed;
  logic              load;
  logic [TIME_W-1:0] time_in;
  logic [PWR_W-1:0]  power;
  logic              mag_on, beep, done;
  logic [TIME_W-1:0] time_left;
  logic [1:0]        state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int on_cnt;
  logic [31:0] sb_q[$];

  mag_cook_controller #(
    .TIME_W(TIME_W), .PWR_W(PWR_W), .ADD_SECS(30), .BEEP_TICKS(3)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .load(load), .time_in(time_in),
    .power(power), .mag_on(mag_on), .beep(beep), .done(done),
    .time_left(time_left), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] exp);
    sb_q.push_back(exp);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    total_cnt++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: observed %0d but no expected value queued", tag, obs);
      $error("check %s had no expected value", tag);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) pass_cnt++;
      else begin
        $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $error("check %s observed %0d expected %0d", tag, obs, exp);
      end
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  // btn: 0=start 1=stop 2=clear; held low one edge, then released one edge
  task automatic press(input int btn);
    if (btn == 0) startn = 1'b0;
    else if (btn == 1) stopn = 1'b0;
    else clearn = 1'b0;
    cyc(1);
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    cyc(1);
  endtask

  task automatic load_time(input int t);
    time_in = TIME_W'(t);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; load = 1'b0; time_in = '0; power = '0;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    push(0); chk("rst_state", 32'(state));
    push(0); chk("rst_time", 32'(time_left));
    push(0); chk("rst_mag", 32'(mag_on));
    push(0); chk("rst_beep", 32'(beep));
    push(0); chk("rst_done", 32'(done));

    $display("scenario 1: full cook of 5 s at max power");
    load_time(5);
    push(5); chk("s1_load", 32'(time_left));
    power = 3'd7;
    press(0);
    push(1); chk("s1_state_cook", 32'(state));
    push(5); chk("s1_time_start", 32'(time_left));
    for (int k = 0; k < 5; k++) begin
      push(1); chk("s1_mag", 32'(mag_on));
      pulse_tick();
      if (k < 4) begin
        push(32'(4 - k)); chk("s1_count", 32'(time_left));
      end
    end
    push(3); chk("s1_state_done", 32'(state));
    push(1); chk("s1_done_pulse", 32'(done));
    push(0); chk("s1_time_zero", 32'(time_left));
    push(1); chk("s1_beep_on", 32'(beep));
    cyc(1);
    push(0); chk("s1_done_clear", 32'(done));
    for (int b = 0; b < 3; b++) begin
      push(1); chk("s1_beep_held", 32'(beep));
      push(3); chk("s1_state_held", 32'(state));
      pulse_tick();
      cyc(1);
    end
    push(0); chk("s1_beep_off", 32'(beep));
    push(0); chk("s1_state_idle", 32'(state));

    $display("scenario 2: power 1 duty over 16 ticks");
    load_time(16);
    power = 3'd1;
    press(0);
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      push(((k % 8) <= 1) ? 32'd1 : 32'd0); chk("s2_duty", 32'(mag_on));
      on_cnt += int'(mag_on);
      pulse_tick();
      cyc(1);
    end
    push(3); chk("s2_state_done", 32'(state));
    push(4); chk("s2_on_ticks", 32'(on_cnt));
    press(2);
    push(0); chk("s2_clear_done", 32'(state));
    push(0); chk("s2_beep_cut", 32'(beep));

    $display("scenario 3: door open pauses, resume at 10");
    load_time(10);
    power = 3'd7;
    press(0);
    push(1); chk("s3_cook", 32'(state));
    door_closed = 1'b0;
    #1;
    push(0); chk("s3_mag_gate", 32'(mag_on));
    push(1); chk("s3_still_cook", 32'(state));
    cyc(1);
    push(2); chk("s3_paused", 32'(state));
    push(10); chk("s3_time_kept", 32'(time_left));
    door_closed = 1'b1;
    #1;
    push(0); chk("s3_mag_paused", 32'(mag_on));
    press(0);
    push(1); chk("s3_resume", 32'(state));
    push(10); chk("s3_resume_time", 32'(time_left));
    push(1); chk("s3_mag_resume", 32'(mag_on));
    press(2);
    push(0); chk("s3_clear_state", 32'(state));
    push(0); chk("s3_clear_time", 32'(time_left));

    $display("scenario 4: quick start, extend, saturate");
    press(0);
    push(1); chk("s4_quick_state", 32'(state));
    push(30); chk("s4_quick_time", 32'(time_left));
    press(0);
    push(60); chk("s4_extend", 32'(time_left));
    press(2);
    load_time(4080);
    press(0);
    push(4080); chk("s4_big_start", 32'(time_left));
    press(0);
    push(4095); chk("s4_saturate", 32'(time_left));
    press(2);
    push(0); chk("s4_cleared", 32'(state));

    $display("scenario 5: clear+stop together, stop+tick together");
    load_time(20);
    press(0);
    clearn = 1'b0; stopn = 1'b0;
    cyc(1);
    push(0); chk("s5_clear_wins_state", 32'(state));
    push(0); chk("s5_clear_wins_time", 32'(time_left));
    clearn = 1'b1; stopn = 1'b1;
    cyc(1);
    load_time(20);
    press(0);
    pulse_tick();
    cyc(1);
    push(19); chk("s5_tick_dec", 32'(time_left));
    stopn = 1'b0; tick = 1'b1;
    cyc(1);
    stopn = 1'b1; tick = 1'b0;
    push(2); chk("s5_stop_tick_state", 32'(state));
    push(19); chk("s5_stop_tick_time", 32'(time_left));
    cyc(1);
    press(1);
    push(0); chk("s5_stop_paused_state", 32'(state));
    push(0); chk("s5_stop_paused_time", 32'(time_left));

    $display("scenario 6: async reset mid-cook, start held through reset");
    load_time(10);
    press(0);
    pulse_tick();
    cyc(1);
    push(1); chk("s6_mag_before", 32'(mag_on));
    startn = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    push(0); chk("s6_async_mag", 32'(mag_on));
    push(0); chk("s6_async_state", 32'(state));
    push(0); chk("s6_async_time", 32'(time_left));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(3);
    push(0); chk("s6_held_no_start", 32'(state));
    push(0); chk("s6_held_time", 32'(time_left));
    startn = 1'b1;
    cyc(1);
    startn = 1'b0;
    cyc(1);
    push(1); chk("s6_repress_state", 32'(state));
    push(30); chk("s6_repress_time", 32'(time_left));
    startn = 1'b1;
    cyc(1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
